serial_sequence_generator_fsm: RTL and testbench

FSM-based serial bit-sequence generator. It is the transmit-side counterpart of the team's serial sequence detectors. A programmable pattern of up to `MAX_LEN` bits is accepted through a valid/ready handshake and emitted MSB-first on a one-bit stream, optionally repeated with idle gaps between copies. It drives detector inputs in loopback benches and supplies framed test patterns to downstream serial logic.

---
 rtl/serial_seq_gen_pkg.sv | 21 ++
 rtl/pattern_shift_reg.sv | 28 ++
 rtl/serial_sequence_generator_fsm.sv | 152 +++++++++++++++
 tb/tb_serial_sequence_generator_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_seq_gen_pkg.sv
// Shared types, default parameters and helpers for the serial sequence generator.
package serial_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_REP_W   = 4;
    localparam int DEF_GAP_W   = 3;

    // Effective pattern length: requested length clamped to the register size.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, shift-left pattern register; the MSB is the bit on the wire.
module pattern_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Load wins over shift so a reload on the last bit of a copy starts the next copy cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_sequence_generator_fsm.sv
// Serial bit-sequence generator: emits a programmable pattern MSB-first,
// optionally repeated with idle gaps, and pulses done after the final copy.
module serial_sequence_generator_fsm
    import serial_seq_gen_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int REP_W   = DEF_REP_W,
    parameter  int GAP_W   = DEF_GAP_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeats,
    input  logic [GAP_W-1:0]   gap,
    output logic               a,
    output logic               a_valid,
    output logic               done
);

    state_t state, state_next;

    // Command registers kept for reloading each copy.
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [GAP_W-1:0]   gap_q;

    logic [LEN_W-1:0]   bit_cnt, bit_cnt_next;
    logic [REP_W-1:0]   copy_cnt, copy_cnt_next;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;

    logic               accept;
    logic [LEN_W-1:0]   len_eff_in;
    logic [MAX_LEN-1:0] accept_val;
    logic [MAX_LEN-1:0] reload_val;

    logic               sr_load;
    logic               sr_shift;
    logic [MAX_LEN-1:0] sr_d;
    logic               sr_msb;

    assign accept     = start_valid && (state == IDLE);
    assign len_eff_in = LEN_W'(clamp_len(32'(len), MAX_LEN));
    // Left-align the right-aligned pattern so its first bit sits at the MSB.
    assign accept_val = pattern << (LEN_W'(MAX_LEN) - len_eff_in);
    assign reload_val = pat_q << (LEN_W'(MAX_LEN) - len_q);

    pattern_shift_reg #(
        .WIDTH (MAX_LEN)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .msb   (sr_msb)
    );

    // State and counter registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            copy_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            copy_cnt <= copy_cnt_next;
            gap_cnt  <= gap_cnt_next;
        end
    end

    // Capture the command fields at the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            len_q <= '0;
            gap_q <= '0;
        end else if (accept) begin
            pat_q <= pattern;
            len_q <= len_eff_in;
            gap_q <= gap;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        copy_cnt_next = copy_cnt;
        gap_cnt_next  = gap_cnt;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_d          = reload_val;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    sr_load       = 1'b1;
                    sr_d          = accept_val;
                    bit_cnt_next  = len_eff_in;
                    copy_cnt_next = repeats;
                    gap_cnt_next  = '0;
                    state_next    = (len_eff_in == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                sr_shift     = 1'b1;
                bit_cnt_next = bit_cnt - 1'b1;
                if (bit_cnt == LEN_W'(1)) begin
                    if (copy_cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        copy_cnt_next = copy_cnt - 1'b1;
                        sr_load       = 1'b1;
                        bit_cnt_next  = len_q;
                        if (gap_q != '0) begin
                            gap_cnt_next = gap_q;
                            state_next   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_next = gap_cnt - 1'b1;
                end
                if (gap_cnt <= GAP_W'(1)) begin
                    state_next = SEND;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode from registered state only.
    always_comb begin
        a_valid     = (state == SEND);
        a           = (state == SEND) && sr_msb;
        done        = (state == DONE);
        start_ready = (state == IDLE);
    end

endmodule

// File: tb/tb_serial_sequence_generator_fsm.sv
// Scoreboard bench for serial_sequence_generator_fsm: per-cycle expected
// {a_valid, a, done, start_ready} vectors are queued at command time.
module tb_serial_sequence_generator_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] repeats = '0;
    logic [2:0] gap = '0;
    logic       a;
    logic       a_valid;
    logic       done;

    int checks = 0;
    int passed = 0;
    logic [3:0] exp_q[$];

    serial_sequence_generator_fsm #(
        .MAX_LEN (8),
        .REP_W   (4),
        .GAP_W   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .repeats     (repeats),
        .gap         (gap),
        .a           (a),
        .a_valid     (a_valid),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs for cycles 1.. after accept, ending with the idle cycle.
    task automatic push_cmd(input logic [7:0] p, input int l, input int rep, input int g);
        int le;
        le = (l > 8) ? 8 : l;
        if (le > 0) begin
            for (int c = 0; c <= rep; c++) begin
                for (int k = 0; k < le; k++) exp_q.push_back({1'b1, p[le-1-k], 1'b0, 1'b0});
                if (c < rep) for (int j = 0; j < g; j++) exp_q.push_back(4'b0000);
            end
        end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
    endtask

    task automatic drive(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [2:0] g);
        pattern = p; len = l; repeats = r; gap = g; start_valid = 1'b1;
        push_cmd(p, int'(l), int'(r), int'(g));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #3;
        got = {a_valid, a, done, start_ready};
        checks++;
        if (got !== 4'b0001) $display("FAIL reset_hold got=%b exp=0001", got);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        step();
        got = {a_valid, a, done, start_ready};
        checks++;
        if (got !== 4'b0001) $display("FAIL reset_idle got=%b exp=0001", got);
        else passed++;
    endtask

    task automatic test_cmd(input string name, input logic [7:0] p, input logic [3:0] l,
                            input logic [3:0] r, input logic [2:0] g);
        logic [3:0] got, e;
        int cyc;
        cyc = 0;
        drive(p, l, r, g);
        while (exp_q.size() > 0) begin
            step();
            cyc++;
            start_valid = 1'b0;
            e = exp_q.pop_front();
            got = {a_valid, a, done, start_ready};
            checks++;
            if (got !== e) $display("FAIL %s cycle %0d got=%b exp=%b", name, cyc, got, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, e;
        drive(8'b0000_1010, 4'd4, 4'd0, 3'd0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            step();
            start_valid = 1'b0;
            e = exp_q.pop_front();
            got = {a_valid, a, done, start_ready};
            checks++;
            if (got !== e) $display("FAIL reset_mid_pre cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        got = {a_valid, a, done, start_ready};
        checks++;
        if (got !== 4'b0001) $display("FAIL reset_mid_async got=%b exp=0001", got);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {a_valid, a, done, start_ready};
            checks++;
            if (got !== 4'b0001) $display("FAIL reset_mid_held got=%b exp=0001", got);
            else passed++;
        end
        @(negedge clk) rst_n = 1'b1;
        test_cmd("reset_mid_rerun", 8'b0000_1010, 4'd4, 4'd0, 3'd0);
    endtask

    task automatic test_held();
        logic [3:0] got, e;
        int cyc, phase;
        cyc = 0;
        phase = 0;
        drive(8'b0000_1010, 4'd4, 4'd0, 3'd0);
        while (exp_q.size() > 0) begin
            step();
            cyc++;
            e = exp_q.pop_front();
            got = {a_valid, a, done, start_ready};
            checks++;
            if (got !== e) $display("FAIL held cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
            if (exp_q.size() == 0 && phase == 0) begin
                phase = 1;
                drive(8'b0000_0110, 4'd3, 4'd0, 3'd0);
            end else if (exp_q.size() == 0) begin
                start_valid = 1'b0;
            end else begin
                pattern = 8'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd("single",       8'b0000_1010, 4'd4, 4'd0, 3'd0);
        test_cmd("repeat_gap",   8'b0011_0011, 4'd6, 4'd2, 3'd2);
        test_cmd("zero_len",     8'hFF,        4'd0, 4'd3, 3'd0);
        test_cmd("clamp",        8'hA5,        4'd9, 4'd0, 3'd0);
        test_cmd("back_to_back", 8'b0000_0101, 4'd3, 4'd3, 3'd0);
        test_cmd("max_rep_gap",  8'b0000_0010, 4'd2, 4'd15, 3'd7);
        test_cmd("full_len",     8'h3C,        4'd8, 4'd1, 3'd1);
        test_reset_mid();
        test_held();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
